// File: rtl/movk_sequencer.sv
`default_nettype none
// ==========================================================================
// movk_sequencer : splits a 64-bit constant into MOVZ/MOVK (imm16, hw) steps
// Revision 1.0
// ==========================================================================
module movk_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] value,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] imm16,
   output logic [1:0]  hw,
   output logic        is_movz,
   output logic        last,
   output logic [2:0]  count,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] val_q, val_d;
   logic [3:0]  mask_q, mask_d;
   logic        first_q, first_d;
   logic [2:0]  count_q, count_d;
   logic        busy_q, busy_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] imm16_q, imm16_d;
   logic [1:0]  hw_q, hw_d;
   logic        is_movz_q, is_movz_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic [3:0]  nz;
   logic [1:0]  idx_d;

   function automatic logic [1:0] lowest(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else if (m[3]) return 2'd3;
      else           return 2'd0;
   endfunction

   function automatic logic [2:0] popcnt(input logic [3:0] m);
      return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
   endfunction

   function automatic logic single(input logic [3:0] m);
      return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
   endfunction

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      mask_d  = mask_q;
      first_d = first_q;
      count_d = count_q;
      for (int i = 0; i < 4; i++) begin
         nz[i] = |value[16*i +: 16];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               val_d   = value;
               // an all-zero constant still needs one MOVZ #0
               mask_d  = (nz == 4'd0) ? 4'b0001 : nz;
               first_d = 1'b1;
               count_d = popcnt(mask_d);
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               mask_d  = mask_q & ~(4'b0001 << lowest(mask_q));
               first_d = 1'b0;
               if (single(mask_q)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            count_d = 3'd0;
         end
         default: state_d = IDLE;
      endcase

      // outputs are precomputed from next state so they leave a flop
      idx_d       = lowest(mask_d);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == EMIT);
      done_d      = (state_d == DONE);
      imm16_d     = out_valid_d ? val_d[{idx_d, 4'b0000} +: 16] : 16'h0000;
      hw_d        = out_valid_d ? idx_d : 2'd0;
      is_movz_d   = out_valid_d & first_d;
      last_d      = out_valid_d & single(mask_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         val_q       <= 64'd0;
         mask_q      <= 4'd0;
         first_q     <= 1'b0;
         count_q     <= 3'd0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         imm16_q     <= 16'h0000;
         hw_q        <= 2'd0;
         is_movz_q   <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         val_q       <= val_d;
         mask_q      <= mask_d;
         first_q     <= first_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         imm16_q     <= imm16_d;
         hw_q        <= hw_d;
         is_movz_q   <= is_movz_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign imm16     = imm16_q;
   assign hw        = hw_q;
   assign is_movz   = is_movz_q;
   assign last      = last_q;
   assign count     = count_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_movk_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_movk_sequencer : directed and randomized checks of movk_sequencer
// Revision 1.0
// ==========================================================================
module tb_movk_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, out_ready;
   logic [63:0] value;
   logic        busy, out_valid, is_movz, last, done;
   logic [15:0] imm16;
   logic [1:0]  hw;
   logic [2:0]  count;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [15:0] imm;
      logic [1:0]  hw;
   } emis_t;

   always #5 clk = ~clk;

   movk_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .value     (value),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm16     (imm16),
      .hw        (hw),
      .is_movz   (is_movz),
      .last      (last),
      .count     (count),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"},    {63'd0, busy},      64'd0);
      chk({tag, ".valid"},   {63'd0, out_valid}, 64'd0);
      chk({tag, ".imm16"},   {48'd0, imm16},     64'd0);
      chk({tag, ".hw"},      {62'd0, hw},        64'd0);
      chk({tag, ".is_movz"}, {63'd0, is_movz},   64'd0);
      chk({tag, ".last"},    {63'd0, last},      64'd0);
      chk({tag, ".count"},   {61'd0, count},     64'd0);
      chk({tag, ".done"},    {63'd0, done},      64'd0);
   endtask

   // Called at a negedge with the DUT idle; returns at the first idle negedge after done.
   task automatic run_seq(input logic [63:0] v, input int stall_pct, input int hold,
                          input bit start_busy);
      emis_t q[$];
      int    n;
      for (int i = 0; i < 4; i++) begin
         if (v[16*i +: 16] != 16'h0000) q.push_back('{v[16*i +: 16], 2'(i)});
      end
      if (q.size() == 0) q.push_back('{16'h0000, 2'd0});
      n = q.size();

      start     = 1'b1;
      value     = v;
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      start = start_busy;
      value = start_busy ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};

      for (int k = 0; k < n; k++) begin
         int waited = 0;
         bit rdy;
         do begin
            chk($sformatf("e%0d.busy", k),    {63'd0, busy},      64'd1);
            chk($sformatf("e%0d.valid", k),   {63'd0, out_valid}, 64'd1);
            chk($sformatf("e%0d.imm16", k),   {48'd0, imm16},     {48'd0, q[k].imm});
            chk($sformatf("e%0d.hw", k),      {62'd0, hw},        {62'd0, q[k].hw});
            chk($sformatf("e%0d.is_movz", k), {63'd0, is_movz},   {63'd0, k == 0});
            chk($sformatf("e%0d.last", k),    {63'd0, last},      {63'd0, k == n - 1});
            chk($sformatf("e%0d.count", k),   {61'd0, count},     64'(n));
            chk($sformatf("e%0d.done", k),    {63'd0, done},      64'd0);
            rdy = (waited >= hold) && (int'($urandom_range(99)) >= stall_pct);
            if (waited > hold + 40) rdy = 1'b1;
            out_ready = rdy;
            @(negedge clk);
            waited++;
         end while (!rdy);
      end

      out_ready = 1'($urandom_range(1));
      chk("fin.done",  {63'd0, done},      64'd1);
      chk("fin.valid", {63'd0, out_valid}, 64'd0);
      chk("fin.busy",  {63'd0, busy},      64'd1);
      @(negedge clk);
      start = 1'b0;
      chk("idle.busy",  {63'd0, busy},      64'd0);
      chk("idle.done",  {63'd0, done},      64'd0);
      chk("idle.valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      logic [63:0] rv;

      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      value     = 64'd0;
      repeat (3) @(negedge clk);
      // reset must win over a simultaneous start
      start = 1'b1;
      value = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      chk_all_zero("rst");
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk_all_zero("post_rst");

      run_seq(64'h0000_0000_0000_0000, 0, 0, 1'b0);
      run_seq(64'h1234_0000_0000_5678, 0, 0, 1'b0);
      run_seq(64'hFFFF_0000_ABCD_0001, 0, 0, 1'b0);
      run_seq(64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
      run_seq(64'h0000_1111_0000_2222, 0, 5, 1'b0);
      run_seq(64'h0000_1111_0000_2222, 0, 1, 1'b0);
      run_seq(64'h0000_0000_0000_5678, 30, 1, 1'b1);
      run_seq(64'h0000_0000_0000_00AA, 0, 0, 1'b0);

      // abandon a 4-emission sequence after its first transfer
      start     = 1'b1;
      value     = 64'hDEAD_BEEF_CAFE_F00D;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid.imm0", {48'd0, imm16}, 64'h0000_0000_0000_F00D);
      @(negedge clk);
      chk("mid.hw1", {62'd0, hw}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_rst");
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("mid_after");
      run_seq(64'h0000_0000_0000_00AA, 0, 0, 1'b0);

      repeat (40) begin
         for (int i = 0; i < 4; i++) begin
            rv[16*i +: 16] = ($urandom_range(2) == 0) ? 16'h0000 : 16'($urandom);
         end
         run_seq(rv, int'($urandom_range(60)), int'($urandom_range(2)),
                 1'($urandom_range(1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/movk_sequencer.md
# movk_sequencer

Splits a 64-bit constant into the MOVZ/MOVK instruction sequence that rebuilds it one halfword at a time. It emits one (imm16, hw) pair per handshake and skips zero halfwords. It is the decomposition counterpart of the halfword-insert path in the execute stage. It sits in front of the instruction queue and materializes wide immediates for the CPU.

## Interface
- No parameters. Data width is fixed at 64 bits, with 16-bit halfwords.
- clk  input  1  Rising-edge clock.
- reset  input  1  Synchronous, active-high reset.
- start  input  1  Request to decompose `value`. Sampled only in IDLE.
- value  input  64  Constant to decompose. Captured on an accepted start.
- busy  output  1  High in any state other than IDLE.
- out_valid  output  1  An instruction is presented on imm16/hw/is_movz/last.
- out_ready  input  1  Consumer accepts the presented instruction when out_valid is high on the same edge.
- imm16  output  16  Halfword payload.
- hw  output  2  Halfword index; shift amount is hw*16.
- is_movz  output  1  1 = MOVZ (first emission), 0 = MOVK.
- last  output  1  Presented instruction is the final one of the sequence.
- count  output  3  Total emissions for the current sequence (1..4). Valid while busy.
- done  output  1  One-cycle pulse after the final transfer.

## Operation
- States:
  - IDLE: start=1 captures `value` into val_q. It also computes mask_q[3:0], where bit i = (val_q[16i+15:16i] != 0). Next state is EMIT.
  - EMIT: presents the halfword at idx = lowest set bit of mask_q.
  - DONE: asserts done for one cycle, then returns to IDLE.
- All-zero value: mask_q is forced to 4'b0001. Result is a single MOVZ, imm16=0, hw=0.
- count = popcount of the forced mask, captured at start.
- Outputs in EMIT:
  - imm16 = val_q[16*idx+15 : 16*idx]
  - hw = idx
  - is_movz = 1 only for the first emission of the sequence
  - last = (mask_q has exactly one bit set)
- Transfer on out_valid && out_ready:
  - clear mask_q[idx] and clear is_movz.
  - if last, go to DONE; otherwise stay in EMIT.
- Emission order is strictly ascending hw.
- start is ignored when not in IDLE; val_q is never overwritten mid-sequence.
- `value` may change freely after the capture edge.

## Timing
- Reset (synchronous, checked at the clk edge):
  - state = IDLE, mask_q = 0, val_q = 0.
  - busy, out_valid, imm16, hw, is_movz, last, count and done are all 0.
  - Reset mid-sequence abandons it with no done pulse.
  - Reset dominates a simultaneous start.
- Outputs are registered or decoded only from registered state, with no combinational path from out_ready or start to any output.
- Latency: start sampled at edge N gives out_valid=1 and busy=1 from cycle N+1.
- With out_ready held at 1, k emissions occupy cycles N+1..N+k.
  - done=1 and out_valid=0 in cycle N+k+1; busy is still 1.
  - IDLE resumes at N+k+2, the earliest next accepted start edge.
- Backpressure: while out_valid=1 and out_ready=0, imm16/hw/is_movz/last/count hold exactly. There is no limit on stall length.
- out_ready while out_valid=0 has no effect.
- out_valid never drops without a transfer, except on reset.

## Test plan
- **All-zero value:** reset, then start with value=0, out_ready=1.
  - Expect exactly one emission: imm16=0x0000, hw=0, is_movz=1, last=1, count=1.
  - Expect a done pulse 2 cycles after start, and busy low the cycle after.
- **Sparse value:** start with value=0x1234_0000_0000_5678, out_ready=1.
  - Expect (0x5678, hw=0, MOVZ, last=0), then (0x1234, hw=3, MOVK, last=1), with count=2.
- **Dense value:** start with value=0xFFFF_0000_ABCD_0001.
  - Expect (0x0001, hw0, MOVZ), (0xABCD, hw1, MOVK), (0xFFFF, hw3, MOVK, last).
  - Then 0xDEAD_BEEF_CAFE_F00D yields 4 emissions, hw 0..3, count=4.
- **Backpressure:** value=0x0000_1111_0000_2222, with out_ready low for 5 cycles, then pulsed high for 1 cycle at a time.
  - Outputs must be stable during every stall.
  - Each pulse transfers exactly one instruction; done follows the final pulse.
- **Start while busy:** assert start with value=0xFFFF_FFFF_FFFF_FFFF during an active sequence for 0x5678.
  - The new value is ignored and the original sequence completes unchanged.
  - A start in the first IDLE cycle after done is accepted.
- **Reset mid-sequence:** reset after the first transfer of a 4-emission sequence.
  - Next cycle: all outputs 0, no done pulse.
  - A subsequent start with 0x0000_0000_0000_00AA yields a single MOVZ 0x00AA, hw=0.
